// File: rtl/bcd_to_bin.sv
// Packed 8-digit BCD to 27-bit binary converter.
// Works through the digits one per clock, most-significant first, using acc = acc*10 + digit.
// Handshake: start is accepted only in IDLE; busy is high while converting; done pulses once at completion.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for start; binary/err hold the last completed result
//   CONVERT | one digit accumulated per clock, 8 clocks total
module bcd_to_bin #(
  parameter int N_DIGITS = 8,
  parameter int BIN_W    = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       one,
  input  logic [3:0]       ten,
  input  logic [3:0]       hundred,
  input  logic [3:0]       thousands,
  input  logic [3:0]       ten_thousands,
  input  logic [3:0]       hundred_thousands,
  input  logic [3:0]       millions,
  input  logic [3:0]       ten_millions,
  output logic [BIN_W-1:0] binary,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int SR_W  = 4 * N_DIGITS;
  localparam int CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_DIGITS - 1);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t           state, state_nxt;
  logic [SR_W-1:0]  sr, sr_nxt;
  logic [BIN_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             eflag, eflag_nxt;
  logic [BIN_W-1:0] binary_nxt;
  logic             busy_nxt, done_nxt, err_nxt;

  logic [3:0]       digit;
  logic             digit_bad;
  logic [BIN_W-1:0] acc_step;

  // Current top digit and the acc*10 + digit step. The multiply by ten is done as
  // shift-and-add with 4 extra bits of headroom, and the sum is then truncated,
  // so an out-of-range digit simply wraps instead of saturating.
  always_comb begin
    digit     = sr[SR_W-1 -: 4];
    digit_bad = (digit > 4'd9);
    acc_step  = BIN_W'(({4'b0000, acc} << 3) + ({4'b0000, acc} << 1)
                       + (BIN_W + 4)'(digit));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and datapath updates; every output gets its next value here.
  always_comb begin
    state_nxt  = state;
    sr_nxt     = sr;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    eflag_nxt  = eflag;
    binary_nxt = binary;
    err_nxt    = err;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          sr_nxt    = {ten_millions, millions, hundred_thousands, ten_thousands,
                       thousands, hundred, ten, one};
          acc_nxt   = '0;
          cnt_nxt   = '0;
          eflag_nxt = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = CONVERT;
        end
      end
      CONVERT: begin
        acc_nxt   = acc_step;
        sr_nxt    = {sr[SR_W-5:0], 4'h0};
        cnt_nxt   = cnt + 1'b1;
        eflag_nxt = eflag | digit_bad;
        if (cnt == CNT_LAST) begin
          binary_nxt = acc_step;
          err_nxt    = eflag | digit_bad;
          done_nxt   = 1'b1;
          busy_nxt   = 1'b0;
          cnt_nxt    = '0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output registers; all outputs are driven straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr     <= '0;
      acc    <= '0;
      cnt    <= '0;
      eflag  <= 1'b0;
      binary <= '0;
      err    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      sr     <= sr_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      eflag  <= eflag_nxt;
      binary <= binary_nxt;
      err    <= err_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

endmodule
